// File: rtl/pipeline_types_pkg.sv
// pipeline_types: shared pipeline register layouts, ALU op encoding and RV32I opcodes
package pipeline_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instruction;
    } if_id_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        alu_op_t     alu_op;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        alu_src_imm;
        logic        lui;
        logic        auipc;
        logic        illegal;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '0;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // alt selects SUB/SRA; caller decides when bit 30 is meaningful
    function automatic alu_op_t alu_from_funct(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// regfile: 32x32 register file, two read ports, one write port, write-through bypass
module regfile (
    input  logic        iClk,
    input  logic        nRst,
    input  logic [4:0]  iRa1,
    input  logic [4:0]  iRa2,
    output logic [31:0] oRd1,
    output logic [31:0] oRd2,
    input  logic        iWe,
    input  logic [4:0]  iWa,
    input  logic [31:0] iWd
);
    logic [31:0] regs_q [32];
    logic        wr;

    assign wr = iWe && (iWa != 5'd0);

    // x0 is never written, so its reset value of zero keeps it hard-wired
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) regs_q <= '{default: '0};
        else if (wr) regs_q[iWa] <= iWd;
    end

    // same-cycle writes are forwarded to readers
    always_comb begin
        oRd1 = (wr && iWa == iRa1) ? iWd : regs_q[iRa1];
        oRd2 = (wr && iWa == iRa2) ? iWd : regs_q[iRa2];
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode, register read and load-use hazard detection
module decode_stage
    import pipeline_types::*;
(
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iEn,
    input  logic        iStall,
    input  logic        iFlush,
    input  if_id_t      iIF,
    input  logic        iWB_En,
    input  logic [4:0]  iWB_Rd,
    input  logic [31:0] iWB_Data,
    input  logic        iEX_MemRd,
    input  logic [4:0]  iEX_Rd,
    output logic        oStall,
    output id_ex_t      oEX
);
    logic [31:0] ins, rd1, rd2, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        rs1_used, rs2_used, hazard;
    id_ex_t      dec, ex_d, ex_q;

    assign ins   = iIF.instruction;
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    regfile u_rf (
        .iClk(iClk), .nRst(nRst),
        .iRa1(ins[19:15]), .iRa2(ins[24:20]),
        .oRd1(rd1), .oRd2(rd2),
        .iWe(iWB_En), .iWa(iWB_Rd), .iWd(iWB_Data)
    );

    // control and immediate decode; unused register fields are zeroed so they cannot alias a hazard
    always_comb begin
        dec      = ID_EX_BUBBLE;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (ins[6:0])
            OPC_LUI:    begin dec.reg_we = 1'b1; dec.lui = 1'b1; dec.alu_src_imm = 1'b1; dec.imm = imm_u; end
            OPC_AUIPC:  begin dec.reg_we = 1'b1; dec.auipc = 1'b1; dec.alu_src_imm = 1'b1; dec.imm = imm_u; end
            OPC_JAL:    begin dec.reg_we = 1'b1; dec.jal = 1'b1; dec.imm = imm_j; end
            OPC_JALR:   begin dec.reg_we = 1'b1; dec.jalr = 1'b1; dec.alu_src_imm = 1'b1; dec.imm = imm_i; rs1_used = 1'b1; end
            OPC_BRANCH: begin dec.branch = 1'b1; dec.alu_op = ALU_SUB; dec.imm = imm_b; rs1_used = 1'b1; rs2_used = 1'b1; end
            OPC_LOAD:   begin dec.reg_we = 1'b1; dec.mem_rd = 1'b1; dec.alu_src_imm = 1'b1; dec.imm = imm_i; rs1_used = 1'b1; end
            OPC_STORE:  begin dec.mem_wr = 1'b1; dec.alu_src_imm = 1'b1; dec.imm = imm_s; rs1_used = 1'b1; rs2_used = 1'b1; end
            OPC_OPIMM:  begin
                dec.reg_we      = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_i;
                dec.alu_op      = alu_from_funct(ins[14:12], ins[14:12] == 3'b101 && ins[30]);
                rs1_used        = 1'b1;
            end
            OPC_OP:     begin
                dec.reg_we = 1'b1;
                dec.alu_op = alu_from_funct(ins[14:12], ins[30]);
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
            end
            default:    dec.illegal = |ins;
        endcase
        dec.pc       = iIF.pc;
        dec.pc4      = iIF.pc4;
        dec.funct3   = dec.illegal ? 3'd0 : ins[14:12];
        dec.rs1      = rs1_used ? ins[19:15] : 5'd0;
        dec.rs2      = rs2_used ? ins[24:20] : 5'd0;
        dec.rd       = dec.reg_we ? ins[11:7] : 5'd0;
        dec.rs1_data = rs1_used ? rd1 : 32'd0;
        dec.rs2_data = rs2_used ? rd2 : 32'd0;
        if (ins == 32'd0) dec = ID_EX_BUBBLE;
    end

    // load-use hazard and next ID/EX value; flush outranks hazard
    always_comb begin
        hazard = iEX_MemRd && (iEX_Rd != 5'd0) &&
                 ((rs1_used && iEX_Rd == ins[19:15]) || (rs2_used && iEX_Rd == ins[24:20]));
        oStall = nRst && hazard && !iFlush && iEn;
        ex_d   = (iFlush || hazard) ? ID_EX_BUBBLE : dec;
    end

    // ID/EX register: holds while disabled or stalled
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) ex_q <= ID_EX_BUBBLE;
        else if (iEn && !iStall) ex_q <= ex_d;
    end

    assign oEX = ex_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector self-checking bench for decode_stage
module tb_decode_stage;
    import pipeline_types::*;

    localparam logic [31:0] ADDI_X6_X5_5  = 32'h00528313;
    localparam logic [31:0] ADD_X8_X7_X0  = 32'h00038433;
    localparam logic [31:0] ADD_X6_X5_X1  = 32'h00128333;
    localparam logic [31:0] ADDI_X6_X0_0  = 32'h00000313;
    localparam logic [31:0] LUI_X5_28     = 32'h000282B7;
    localparam logic [31:0] BEQ_M4        = 32'hFE000EE3;
    localparam logic [31:0] ADD_X8_X7_X9  = 32'h00938433;

    logic        iClk = 1'b0;
    logic        nRst, iEn, iStall, iFlush, iWB_En, iEX_MemRd, oStall;
    logic [4:0]  iWB_Rd, iEX_Rd;
    logic [31:0] iWB_Data;
    if_id_t      iIF;
    id_ex_t      oEX;
    int          tests = 0;
    int          fails = 0;

    decode_stage dut (
        .iClk(iClk), .nRst(nRst), .iEn(iEn), .iStall(iStall), .iFlush(iFlush),
        .iIF(iIF), .iWB_En(iWB_En), .iWB_Rd(iWB_Rd), .iWB_Data(iWB_Data),
        .iEX_MemRd(iEX_MemRd), .iEX_Rd(iEX_Rd), .oStall(oStall), .oEX(oEX)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge iClk);
        @(negedge iClk);
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
        iWB_En   = en;
        iWB_Rd   = rd;
        iWB_Data = d;
    endtask

    initial begin
        nRst = 1'b0; iEn = 1'b1; iStall = 1'b0; iFlush = 1'b0;
        iIF = '{pc: 32'h0, pc4: 32'h4, instruction: ADD_X6_X5_X1};
        wb(1'b0, 5'd0, 32'd0);
        iEX_MemRd = 1'b1; iEX_Rd = 5'd5;
        repeat (2) @(negedge iClk);
        check("rst_bubble", 32'(|oEX), 32'd0);
        check("rst_stall", 32'(oStall), 32'd0);

        nRst = 1'b1; iEX_MemRd = 1'b0;
        wb(1'b1, 5'd5, 32'h1234);
        step;
        check("first_rs1_data", oEX.rs1_data, 32'h1234);
        check("first_rd", 32'(oEX.rd), 32'd6);

        wb(1'b0, 5'd0, 32'd0);
        iIF = '{pc: 32'h100, pc4: 32'h104, instruction: ADDI_X6_X5_5};
        step;
        check("addi_rs1_data", oEX.rs1_data, 32'h1234);
        check("addi_imm", oEX.imm, 32'd5);
        check("addi_rd", 32'(oEX.rd), 32'd6);
        check("addi_reg_we", 32'(oEX.reg_we), 32'd1);
        check("addi_src_imm", 32'(oEX.alu_src_imm), 32'd1);
        check("addi_pc", oEX.pc, 32'h100);

        wb(1'b1, 5'd7, 32'hDEADBEEF);
        iIF.instruction = ADD_X8_X7_X0;
        step;
        check("bypass_rs1", oEX.rs1_data, 32'hDEADBEEF);
        check("add_rd", 32'(oEX.rd), 32'd8);

        wb(1'b1, 5'd0, 32'hFFFFFFFF);
        step;
        check("x0_no_bypass", oEX.rs2_data, 32'd0);
        check("x7_stored", oEX.rs1_data, 32'hDEADBEEF);
        wb(1'b0, 5'd0, 32'd0);
        iIF.instruction = ADDI_X6_X0_0;
        step;
        check("x0_reads_0", oEX.rs1_data, 32'd0);

        iEX_MemRd = 1'b1; iEX_Rd = 5'd5;
        iIF.instruction = ADD_X6_X5_X1;
        #1 check("hazard_stall", 32'(oStall), 32'd1);
        step;
        check("hazard_bubble", 32'(|oEX), 32'd0);
        iEX_Rd = 5'd0;
        #1 check("rd0_no_stall", 32'(oStall), 32'd0);
        iEX_Rd = 5'd5;
        iIF.instruction = LUI_X5_28;
        #1 check("lui_no_stall", 32'(oStall), 32'd0);
        step;
        check("lui_flag", 32'(oEX.lui), 32'd1);
        check("lui_imm", oEX.imm, 32'h00028000);
        check("lui_rd", 32'(oEX.rd), 32'd5);

        iIF.instruction = ADD_X6_X5_X1;
        iFlush = 1'b1;
        #1 check("flush_no_stall", 32'(oStall), 32'd0);
        step;
        check("flush_bubble", 32'(|oEX), 32'd0);
        iFlush = 1'b0; iEX_MemRd = 1'b0;

        iIF.instruction = ADDI_X6_X5_5;
        step;
        iStall = 1'b1; iFlush = 1'b1;
        iIF.instruction = BEQ_M4;
        for (int i = 0; i < 3; i++) begin
            step;
            check($sformatf("hold_rd_%0d", i), 32'(oEX.rd), 32'd6);
            check($sformatf("hold_imm_%0d", i), oEX.imm, 32'd5);
        end
        iStall = 1'b0; iFlush = 1'b0; iEn = 1'b0;
        step;
        check("en_low_hold", 32'(oEX.rd), 32'd6);
        iEn = 1'b1;

        step;
        check("beq_imm", oEX.imm, 32'hFFFFFFFC);
        check("beq_branch", 32'(oEX.branch), 32'd1);
        check("beq_reg_we", 32'(oEX.reg_we), 32'd0);

        iIF.instruction = 32'h0;
        step;
        check("zero_bubble", 32'(|oEX), 32'd0);
        iIF.instruction = 32'hFFFFFFFF;
        step;
        check("illegal_flag", 32'(oEX.illegal), 32'd1);
        check("illegal_ctrl", 32'({oEX.reg_we, oEX.mem_rd, oEX.mem_wr, oEX.branch, oEX.jal, oEX.jalr}), 32'd0);

        iIF.instruction = ADDI_X6_X5_5;
        step;
        check("pre_rst_reg_we", 32'(oEX.reg_we), 32'd1);
        wb(1'b1, 5'd9, 32'h55);
        #2 nRst = 1'b0;
        #1 check("async_rst_bubble", 32'(|oEX), 32'd0);
        @(posedge iClk);
        @(negedge iClk);
        nRst = 1'b1;
        wb(1'b0, 5'd0, 32'd0);
        iIF.instruction = ADD_X8_X7_X9;
        step;
        check("rst_x7_cleared", oEX.rs1_data, 32'd0);
        check("rst_x9_discarded", oEX.rs2_data, 32'd0);
        iIF.instruction = ADDI_X6_X5_5;
        step;
        check("rst_x5_cleared", oEX.rs1_data, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 iClk  input  1  pipeline clock; all state changes on rising edge.
REQ-002 nRst  input  1  reset, asynchronous, active-low.
REQ-003 iEn  input  1  stage enable; when low, the stage holds oEX.
REQ-004 iStall  input  1  downstream stall; when high, the stage holds oEX.
REQ-005 iFlush  input  1  branch/jump redirect from EX; when high, the stage kills the current instruction.
REQ-006 iIF  input  if_id_t  IF/ID pipeline register: pc, pc4, instruction.
REQ-007 iWB_En  input  1  register-file write enable from writeback.
REQ-008 iWB_Rd  input  5  writeback destination register.
REQ-009 iWB_Data  input  32  writeback data.
REQ-010 iEX_MemRd  input  1  the instruction currently in EX is a load.
REQ-011 iEX_Rd  input  5  destination register of the instruction in EX.
REQ-012 oStall  output  1  load-use stall request to IF; combinational.
REQ-013 oEX  output  id_ex_t  ID/EX pipeline register.

Function
REQ-014 Latency: an instruction on iIF SHALL appear decoded on oEX one iClk edge later when iEn=1 and iStall=0.
REQ-015 Register file: 32x32; x0 reads 0; writes to x0 ignored.
REQ-016 Register writes: occur on the rising edge when iWB_En=1 and iWB_Rd!=0, regardless of iEn, iStall or iFlush.
REQ-017 Write-through bypass: a same-cycle read of iWB_Rd (nonzero) with iWB_En=1 SHALL return iWB_Data.
REQ-018 Decoding: RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP SHALL set oEX fields rs1, rs2, rd, funct3, alu_op[3:0], reg_we, mem_rd, mem_wr, branch, jal, jalr, alu_src_imm, lui and auipc.
REQ-019 Immediates: I/S/B/U/J formats, sign-extended to 32 bits; B and J have bit0=0; U has low 12 bits zero; R-type imm=0.
REQ-020 rs1/rs2 usage: "used" flags per format (U/J use neither; I/JALR/LOAD use rs1 only); a register not used by the format SHALL never cause a hazard.
REQ-021 Load-use hazard: hazard = iEX_MemRd & (iEX_Rd!=0) & ((rs1 used & iEX_Rd==rs1) | (rs2 used & iEX_Rd==rs2)).
REQ-022 oStall = hazard & ~iFlush & iEn.
REQ-023 Update priority on each edge with iEn=1 and iStall=0: iFlush -> bubble; else hazard -> bubble; else the decoded instruction.
REQ-024 Bubble definition: all control bits 0, illegal=0; pc, pc4 and data fields zero.
REQ-025 Instruction 0x00000000 SHALL decode as a bubble with illegal=0.
REQ-026 Any other unsupported opcode SHALL set illegal=1 with reg_we, mem_rd, mem_wr, branch, jal and jalr all 0.
REQ-027 Hold: with iStall=1 or iEn=0, oEX SHALL hold its value.
REQ-028 iFlush under hold: iFlush is ignored while iStall=1 (EX re-asserts it).

Reset
REQ-029 nRst low SHALL immediately set oEX to a bubble and clear every register-file entry to 0.
REQ-030 oStall SHALL be 0 during reset.
REQ-031 Reset asserted mid-stall or mid-write SHALL discard the pending write.
REQ-032 The first decode SHALL occur on the first rising edge after nRst deasserts.

Structure
REQ-033 pipeline_types SHALL hold id_ex_t, the alu_op enumeration and the opcode constants.
REQ-034 if_id_t SHALL be reused unchanged.
REQ-035 The register file SHALL be one sub-module, regfile (2 read ports, 1 write port, bypass).
REQ-036 Immediate generation and control decode SHALL be combinational inside decode_stage.
REQ-037 Target size: 150-300 lines of RTL.

Verification
REQ-038 Write x5=0x1234 via WB, then iIF.instruction=0x00528313 (addi x6,x5,5) -> next edge: oEX.rs1_data=0x1234, imm=5, rd=6, reg_we=1, alu_src_imm=1.
REQ-039 Same-cycle WB x7=0xDEADBEEF while decoding add x8,x7,x0 -> oEX.rs1_data=0xDEADBEEF; a WB to x0=0xFFFFFFFF then reading x0 -> 0.
REQ-040 iEX_MemRd=1, iEX_Rd=5, decode add x6,x5,x1 -> oStall=1 and a bubble next edge; with iEX_Rd=0, or lui x5, -> oStall=0.
REQ-041 Hazard and iFlush=1 together -> oStall=0 and a bubble; iStall=1 for 3 cycles -> oEX unchanged throughout.
REQ-042 Decode 0xFE000EE3 (beq, imm=-4) -> imm=0xFFFFFFFC, branch=1, reg_we=0.
REQ-043 0x00000000 -> bubble with illegal=0; 0xFFFFFFFF -> illegal=1.
REQ-044 nRst asserted mid-stream -> oEX bubble immediately and all registers read 0 afterwards.
